// File: rtl/mod_exp_arbiter_pkg.sv
// Shared defaults, FSM encoding and helpers for the exponentiation-engine arbiter.
package mod_exp_arbiter_pkg;

    localparam int DEF_BITS    = 16;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_CNT_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mod_exp_arbiter_rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or above ptr_i, wrapping.
module mod_exp_arbiter_rr_arbiter
    import mod_exp_arbiter_pkg::*;
#(
    parameter int N     = DEF_NUM_REQ,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;
    logic             found;

    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDX_W'(cand);
            if (!found && req_i[cand_idx]) begin
                found = 1'b1;
                idx_o = cand_idx;
            end
        end
        if (found) begin
            gnt_o[idx_o] = 1'b1;
        end
        any_o = found;
    end

endmodule

// File: rtl/mod_exp_arbiter.sv
// Shares one Montgomery exponentiation engine between NUM_REQ requesters, round-robin.
//
// state  | meaning
// IDLE   | waiting for a request; grant and operand capture happen here
// LAUNCH | one-cycle engine start pulse, job counter cleared to 1
// BUSY   | counting cycles until a rising edge of eng_finish
// RESP   | result presented to the owner until it accepts
module mod_exp_arbiter
    import mod_exp_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int BITS    = DEF_BITS,
    parameter int CNT_W   = DEF_CNT_W,
    localparam int IDX_W  = idx_w(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*BITS-1:0] req_base_mont,
    input  logic [NUM_REQ*BITS-1:0] req_exponent,
    input  logic [NUM_REQ*BITS-1:0] req_n,
    input  logic [NUM_REQ*BITS-1:0] req_n_prime,
    input  logic [NUM_REQ*BITS-1:0] req_one_mont,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [BITS-1:0]         rsp_result,
    output logic                    eng_start,
    output logic [BITS-1:0]         eng_base_mont,
    output logic [BITS-1:0]         eng_exponent,
    output logic [BITS-1:0]         eng_n,
    output logic [BITS-1:0]         eng_n_prime,
    output logic [BITS-1:0]         eng_one_mont,
    input  logic                    eng_finish,
    input  logic [BITS-1:0]         eng_result,
    output logic                    busy,
    output logic [IDX_W-1:0]        owner,
    output logic [CNT_W-1:0]        last_cycles
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic             finish_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last_cycles_q, last_cycles_d;
    logic [BITS-1:0]  rsp_result_q, rsp_result_d;
    logic [BITS-1:0]  base_q, base_d;
    logic [BITS-1:0]  exp_q, exp_d;
    logic [BITS-1:0]  n_q, n_d;
    logic [BITS-1:0]  np_q, np_d;
    logic [BITS-1:0]  one_q, one_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic               finish_rise;

    logic [BITS-1:0] base_a [NUM_REQ];
    logic [BITS-1:0] exp_a  [NUM_REQ];
    logic [BITS-1:0] n_a    [NUM_REQ];
    logic [BITS-1:0] np_a   [NUM_REQ];
    logic [BITS-1:0] one_a  [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign base_a[gi] = req_base_mont[gi*BITS +: BITS];
        assign exp_a[gi]  = req_exponent[gi*BITS +: BITS];
        assign n_a[gi]    = req_n[gi*BITS +: BITS];
        assign np_a[gi]   = req_n_prime[gi*BITS +: BITS];
        assign one_a[gi]  = req_one_mont[gi*BITS +: BITS];
    end

    mod_exp_arbiter_rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    // A finish level left over from the previous job must not complete the next one.
    assign finish_rise = eng_finish & ~finish_q;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        last_cycles_d = last_cycles_q;
        rsp_result_d  = rsp_result_q;
        base_d        = base_q;
        exp_d         = exp_q;
        n_d           = n_q;
        np_d          = np_q;
        one_d         = one_q;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    owner_d = gnt_idx;
                    base_d  = base_a[gnt_idx];
                    exp_d   = exp_a[gnt_idx];
                    n_d     = n_a[gnt_idx];
                    np_d    = np_a[gnt_idx];
                    one_d   = one_a[gnt_idx];
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                cnt_d   = CNT_W'(1);
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (finish_rise) begin
                    rsp_result_d  = eng_result;
                    last_cycles_d = cnt_q;
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready[owner_q]) begin
                    rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            finish_q      <= 1'b0;
            cnt_q         <= '0;
            last_cycles_q <= '0;
            rsp_result_q  <= '0;
            base_q        <= '0;
            exp_q         <= '0;
            n_q           <= '0;
            np_q          <= '0;
            one_q         <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            finish_q      <= eng_finish;
            cnt_q         <= cnt_d;
            last_cycles_q <= last_cycles_d;
            rsp_result_q  <= rsp_result_d;
            base_q        <= base_d;
            exp_q         <= exp_d;
            n_q           <= n_d;
            np_q          <= np_d;
            one_q         <= one_d;
        end
    end

    // Grant is combinational; gate with rst so every output reads 0 while reset is held.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (rst && state_q == ST_IDLE) begin
            req_ready = gnt;
        end
        if (state_q == ST_RESP) begin
            rsp_valid[owner_q] = 1'b1;
        end
    end

    assign eng_start     = (state_q == ST_LAUNCH);
    assign busy          = (state_q != ST_IDLE);
    assign owner         = owner_q;
    assign last_cycles   = last_cycles_q;
    assign rsp_result    = rsp_result_q;
    assign eng_base_mont = base_q;
    assign eng_exponent  = exp_q;
    assign eng_n         = n_q;
    assign eng_n_prime   = np_q;
    assign eng_one_mont  = one_q;

endmodule

// File: tb/tb_mod_exp_arbiter.sv
// Scoreboard bench for mod_exp_arbiter with a fixed-latency stub engine (result = base ^ exponent).
module tb_mod_exp_arbiter;

    localparam int NR = 4;
    localparam int B  = 16;
    localparam int CW = 32;
    localparam int ENG_LAT = 10;

    typedef struct packed {
        logic [B-1:0] b, e, n, np, one;
    } job_t;

    typedef struct packed {
        logic [1:0]   idx;
        logic [B-1:0] b, e, n, np, one;
    } rec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NR*B-1:0]   req_base_mont, req_exponent, req_n, req_n_prime, req_one_mont;
    logic [B-1:0]      rsp_result, eng_base_mont, eng_exponent, eng_n, eng_n_prime, eng_one_mont;
    logic [B-1:0]      eng_result;
    logic              eng_start, eng_finish, busy;
    logic [1:0]        owner;
    logic [CW-1:0]     last_cycles;

    mod_exp_arbiter #(.NUM_REQ(NR), .BITS(B), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_base_mont(req_base_mont), .req_exponent(req_exponent), .req_n(req_n),
        .req_n_prime(req_n_prime), .req_one_mont(req_one_mont),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .eng_start(eng_start), .eng_base_mont(eng_base_mont), .eng_exponent(eng_exponent),
        .eng_n(eng_n), .eng_n_prime(eng_n_prime), .eng_one_mont(eng_one_mont),
        .eng_finish(eng_finish), .eng_result(eng_result),
        .busy(busy), .owner(owner), .last_cycles(last_cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub engine: finish rises ENG_LAT cycles after the start pulse, held fin_hold cycles.
    int stub_cnt, fin_left;
    int fin_hold = 2;
    logic [B-1:0] stub_res;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            stub_cnt <= 0;
            fin_left <= 0;
            stub_res <= '0;
        end else begin
            if (eng_start) begin
                stub_cnt <= ENG_LAT;
                stub_res <= eng_base_mont ^ eng_exponent;
            end else if (stub_cnt != 0) begin
                stub_cnt <= stub_cnt - 1;
            end
            if (stub_cnt == 2) fin_left <= fin_hold;
            else if (fin_left != 0) fin_left <= fin_left - 1;
        end
    end
    assign eng_finish = (fin_left != 0);
    assign eng_result = stub_res;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    function automatic logic [B-1:0] get16(input logic [NR*B-1:0] bus, input int i);
        return B'(bus >> (i*B));
    endfunction

    function automatic logic [NR*B-1:0] put16(input logic [NR*B-1:0] bus, input int i,
                                              input logic [B-1:0] v);
        logic [NR*B-1:0] m;
        m = (NR*B)'(16'hFFFF) << (i*B);
        return (bus & ~m) | ((NR*B)'(v) << (i*B));
    endfunction

    // Reference rule: first valid requester scanning upward from the pointer, with wrap.
    function automatic int pick(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    rec_t exp_q[$];
    int   grant_log[$];
    int   gap_log[$];
    int   gnt_cnt [NR];
    int   phase = 0, m_ptr = 0, p0, w;
    int   grant_cyc, start_cyc, rsp_first_cyc, acc_cyc;
    logic [NR-1:0] exp_rdy, exp_rv;
    rec_t rec;

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_rsp_result", 32'(rsp_result), 0);
            chk("rst_eng_start", 32'(eng_start), 0);
            chk("rst_eng_base", 32'(eng_base_mont), 0);
            chk("rst_eng_exp", 32'(eng_exponent), 0);
            chk("rst_eng_ops", 32'(eng_n | eng_n_prime | eng_one_mont), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_owner", 32'(owner), 0);
            chk("rst_last_cycles", last_cycles, 0);
            exp_q.delete();
            phase = 0;
            m_ptr = 0;
        end else begin
            p0 = phase;
            chk("busy", 32'(busy), 32'(p0 != 0));

            exp_rdy = '0;
            w = -1;
            if (p0 == 0 && req_valid != 0) begin
                w = pick(req_valid, m_ptr);
                exp_rdy = NR'(1 << w);
            end
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            if (w >= 0 && (req_valid & req_ready) != 0) begin
                rec.idx = 2'(w);
                rec.b   = get16(req_base_mont, w);
                rec.e   = get16(req_exponent, w);
                rec.n   = get16(req_n, w);
                rec.np  = get16(req_n_prime, w);
                rec.one = get16(req_one_mont, w);
                exp_q.push_back(rec);
                phase = 1;
                grant_cyc = cyc;
                gnt_cnt[w]++;
                grant_log.push_back(w);
                gap_log.push_back(cyc - acc_cyc);
            end

            chk("eng_start", 32'(eng_start), 32'(p0 == 1 && cyc == grant_cyc + 1));
            if (p0 == 1 && eng_start) begin
                chk("eng_base_mont", 32'(eng_base_mont), 32'(exp_q[0].b));
                chk("eng_exponent", 32'(eng_exponent), 32'(exp_q[0].e));
                chk("eng_n", 32'(eng_n), 32'(exp_q[0].n));
                chk("eng_n_prime", 32'(eng_n_prime), 32'(exp_q[0].np));
                chk("eng_one_mont", 32'(eng_one_mont), 32'(exp_q[0].one));
                chk("owner_launch", 32'(owner), 32'(exp_q[0].idx));
                start_cyc = cyc;
                phase = 2;
            end

            exp_rv = '0;
            if (p0 == 3 || (p0 == 2 && cyc == start_cyc + ENG_LAT + 1))
                exp_rv = NR'(1 << exp_q[0].idx);
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            if (exp_rv != 0) begin
                if (p0 == 2) rsp_first_cyc = cyc;
                chk("rsp_result", 32'(rsp_result), 32'(exp_q[0].b ^ exp_q[0].e));
                chk("last_cycles", last_cycles, ENG_LAT);
                chk("owner_resp", 32'(owner), 32'(exp_q[0].idx));
                if ((exp_rv & rsp_valid & rsp_ready) != 0) begin
                    m_ptr = (int'(exp_q[0].idx) + 1) % NR;
                    exp_q.pop_front();
                    phase = 0;
                    acc_cyc = cyc;
                end else begin
                    phase = 3;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    job_t jobs [NR][$];
    int   used [NR];
    logic rand_rdy = 1'b0;
    logic [NR-1:0] rdy_fix = '1;

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            while (used[i] < gnt_cnt[i]) begin
                if (jobs[i].size() != 0) jobs[i].delete(0);
                used[i]++;
            end
            req_valid[i] = (jobs[i].size() != 0);
            if (jobs[i].size() != 0) begin
                req_base_mont = put16(req_base_mont, i, jobs[i][0].b);
                req_exponent  = put16(req_exponent, i, jobs[i][0].e);
                req_n         = put16(req_n, i, jobs[i][0].n);
                req_n_prime   = put16(req_n_prime, i, jobs[i][0].np);
                req_one_mont  = put16(req_one_mont, i, jobs[i][0].one);
            end
        end
        rsp_ready = rand_rdy ? NR'($urandom) : rdy_fix;
    endtask

    task automatic add_job(input int i, input logic [B-1:0] b, input logic [B-1:0] e);
        job_t j;
        j.b = b;
        j.e = e;
        j.n = B'($urandom);
        j.np = B'($urandom);
        j.one = B'($urandom);
        jobs[i].push_back(j);
    endtask

    task automatic wait_done(input string name, input int budget);
        int t = 0;
        int pending;
        do begin
            step();
            t++;
            pending = exp_q.size();
            for (int i = 0; i < NR; i++) pending += jobs[i].size();
        end while ((pending != 0 || phase != 0) && t < budget);
        if (t >= budget) timeout(name);
    endtask

    initial begin
        int lg, t;
        logic [B-1:0] held;
        int exp_all [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_base_mont = '0;
        req_exponent = '0;
        req_n = '0;
        req_n_prime = '0;
        req_one_mont = '0;
        repeat (3) step();
        rst = 1'b1;
        repeat (2) step();

        // Single request from requester 2.
        add_job(2, 16'h1234, 16'h00FF);
        wait_done("single", 100);
        chk("single_latency", 32'(rsp_first_cyc - grant_cyc), 12);
        chk("single_result", 32'(rsp_result), 32'h12CB);
        chk("single_last_cycles", last_cycles, 10);
        chk("eng_base_held", 32'(eng_base_mont), 32'h1234);
        chk("eng_exp_held", 32'(eng_exponent), 32'h00FF);

        // Response backpressure on requester 1 with requester 0 waiting.
        rdy_fix = 4'b1101;
        lg = grant_log.size();
        add_job(1, B'($urandom), B'($urandom));
        t = 0;
        while (grant_log.size() == lg && t < 50) begin step(); t++; end
        if (t >= 50) timeout("bp_grant");
        add_job(0, B'($urandom), B'($urandom));
        t = 0;
        while (rsp_valid != 4'b0010 && t < 50) begin step(); t++; end
        if (t >= 50) timeout("bp_rsp");
        held = rsp_result;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("bp_rsp_valid", 32'(rsp_valid), 32'h2);
            chk("bp_rsp_result", 32'(rsp_result), 32'(held));
            chk("bp_no_grant", 32'(req_ready | NR'(eng_start)), 0);
        end
        rdy_fix = '1;
        wait_done("bp_drain", 100);
        chk("bp_regrant_gap", 32'(gap_log[gap_log.size()-1]), 1);
        chk("bp_regrant_who", 32'(grant_log[grant_log.size()-1]), 0);

        // Lingering finish level across back-to-back jobs.
        fin_hold = 5;
        add_job(0, B'($urandom), B'($urandom));
        add_job(0, B'($urandom), B'($urandom));
        wait_done("linger", 200);
        chk("linger_latency", 32'(rsp_first_cyc - start_cyc), 11);
        chk("linger_gap", 32'(gap_log[gap_log.size()-1]), 1);
        fin_hold = 2;

        // Randomized traffic with random response backpressure.
        rand_rdy = 1'b1;
        for (int j = 0; j < 30; j++) begin
            add_job(int'($urandom_range(0, NR-1)), B'($urandom), B'($urandom));
            repeat ($urandom_range(0, 12)) step();
        end
        wait_done("random", 4000);
        rand_rdy = 1'b0;

        // Reset in BUSY: pointer left at 3, then abort a job from requester 0.
        add_job(2, B'($urandom), B'($urandom));
        wait_done("pre_reset", 100);
        add_job(0, B'($urandom), B'($urandom));
        t = 0;
        while (phase != 2 && t < 50) begin step(); t++; end
        if (t >= 50) timeout("reset_setup");
        repeat (4) step();
        rst = 1'b0;
        #1;
        chk("rst_async_busy", 32'(busy), 0);
        chk("rst_async_owner", 32'(owner), 0);
        chk("rst_async_eng_base", 32'(eng_base_mont), 0);
        repeat (3) step();
        rst = 1'b1;
        repeat (15) step();
        lg = grant_log.size();
        add_job(1, B'($urandom), B'($urandom));
        add_job(3, B'($urandom), B'($urandom));
        wait_done("post_reset", 200);
        chk("post_reset_first", 32'(grant_log[lg]), 1);
        chk("post_reset_second", 32'(grant_log[lg+1]), 3);

        // All four requesters continuously valid.
        lg = grant_log.size();
        for (int i = 0; i < NR; i++) begin
            add_job(i, B'($urandom), B'($urandom));
            add_job(i, B'($urandom), B'($urandom));
        end
        wait_done("all_four", 500);
        for (int k = 0; k < 8; k++) chk("rotate_order", 32'(grant_log[lg+k]), 32'(exp_all[k]));

        // Only requesters 1 and 3 valid.
        lg = grant_log.size();
        for (int k = 0; k < 3; k++) begin
            add_job(1, B'($urandom), B'($urandom));
            add_job(3, B'($urandom), B'($urandom));
        end
        wait_done("skip", 300);
        for (int k = 0; k < 6; k++) chk("skip_order", 32'(grant_log[lg+k]), (k % 2 == 0) ? 1 : 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mod_exp_arbiter.md
Name: mod_exp_arbiter

Overview:
- Shares one montgomery_exp_square engine between NUM_REQ independent requesters.
- Each requester presents a complete Montgomery-domain job: base_mont, exponent, N, N_prime and one_mont.
- The block arbitrates round-robin, latches the winner's operands, pulses the engine start and waits for finish. It returns exp_result to the winner over a valid/ready response channel and reports the job's cycle count.
- Sits between the RSA key/message front-end and the exponentiation engine.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BITS, `BITS (defines.vh), operand width.
- CNT_W, 32, width of the cycle counter and last_cycles.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset, asynchronous, active-low.
- req_valid, in, NUM_REQ, job request per requester.
- req_ready, out, NUM_REQ, one-hot grant/accept.
- req_base_mont, in, NUM_REQ*BITS, slot i at [i*BITS +: BITS]; likewise the next four ports.
- req_exponent, in, NUM_REQ*BITS, exponent.
- req_n, in, NUM_REQ*BITS, modulus N.
- req_n_prime, in, NUM_REQ*BITS, N'.
- req_one_mont, in, NUM_REQ*BITS, R mod N.
- rsp_valid, out, NUM_REQ, one-hot result valid.
- rsp_ready, in, NUM_REQ, result accept.
- rsp_result, out, BITS, result (Montgomery domain), shared by all requesters.
- eng_start, out, 1, one-cycle start pulse to the engine.
- eng_base_mont, eng_exponent, eng_n, eng_n_prime, eng_one_mont, out, BITS each, latched operands.
- eng_finish, in, 1, engine finish.
- eng_result, in, BITS, engine exp_result.
- busy, out, 1, high in every state except IDLE.
- owner, out, $clog2(NUM_REQ), index of the current or last granted requester.
- last_cycles, out, CNT_W, engine cycles of the last completed job.

Behaviour:
- Reset values (rst low, applied immediately):
  - All outputs 0; state IDLE; rr_ptr = 0, so requester 0 has first priority.
  - finish_q = 0; counter = 0.
- Reset asserted mid-job aborts the job silently; no response is issued. The engine is reset by the same rst.
- FSM IDLE:
  - If any req_valid is set, grant the first set bit scanning from rr_ptr upward with wrap.
  - req_ready[g] is high combinationally in that cycle; the handshake is valid & ready.
  - The winner's five operands are registered into the eng_* outputs and owner = g; next state LAUNCH.
- FSM LAUNCH: eng_start = 1 for exactly this cycle; counter cleared to 1; next state BUSY.
- FSM BUSY:
  - counter increments every cycle.
  - Completion is the rising edge of eng_finish (eng_finish & ~finish_q).
  - finish_q is registered every cycle in all states, so a finish still high from the previous job is ignored.
  - On completion: rsp_result <= eng_result, last_cycles <= counter, next state RESP.
- FSM RESP:
  - rsp_valid[owner] = 1; rsp_result is held stable.
  - On rsp_ready[owner]: rr_ptr <= owner+1 (mod NUM_REQ) and next state IDLE.
  - rsp_ready from other requesters is ignored.
- Latency:
  - Grant at cycle T, eng_start at T+1.
  - Finish edge at cycle F gives rsp_valid from F+1.
  - Response accepted at A allows the next grant at A+1; there are no back-to-back grants without one IDLE cycle.
- Requester rules:
  - Once req_valid is asserted, it and the operands are held until req_ready; the arbiter does not check this.
  - A requester may re-request while its own response is pending; it is not granted until IDLE.
- Simultaneous events:
  - All requesters valid: grants rotate 0,1,2,3,0...
  - A requester that is not valid is skipped without losing rotation.
- eng_* operand outputs hold their last values after completion; they are not cleared.
- Counter saturates at all-ones and does not wrap.

Decomposition:
- Shared package/defines: BITS (existing `BITS), FSM state encoding (IDLE, LAUNCH, BUSY, RESP), CNT_W default.
- One natural sub-module: rr_arbiter, a combinational round-robin priority picker.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant and index.
  - Reusable for other shared units (e.g. a shared montgomery multiplier).

Test Plan:
- The bench uses a stub engine with fixed latency 10 cycles after start, finish high for 2 cycles, result = base_mont ^ exponent, and BITS = 16.
- Single request: req 2 with base_mont=0x1234, exponent=0x00FF.
  - req_ready[2] at T, eng_start at T+1 with those operands.
  - rsp_valid[2] with result 0x12CB at T+12; last_cycles = 10.
- All four requesters valid continuously, rsp_ready tied high: grant order 0,1,2,3,0; no requester granted twice before all others are served.
- Response backpressure: rsp_ready[1] held low for 20 cycles.
  - rsp_valid[1] and rsp_result stay stable; no new grant or eng_start in that window.
  - Grant occurs the cycle after acceptance.
- Lingering finish: stub holds finish high 5 cycles, with the next job started 2 cycles after acceptance.
  - The old high level does not complete the new job; completion occurs only on the new rising edge.
- Reset in BUSY: rst low for 3 cycles during a job.
  - All outputs return to 0 immediately; no rsp_valid is issued.
  - After release, a req from requester 3 is granted with rr_ptr restarted at 0.
- Skip behaviour: only requesters 1 and 3 valid, repeatedly → grants alternate 1,3,1,3.
